// File: rtl/decision_pkg.sv
// -----------------------------------------------------------------------------
// decision_pkg
// Shared definitions for the classification vote path and the downstream
// output decision logic: class count, answer width, vote counter width, the
// voter FSM state encoding and the class-code range check.
// -----------------------------------------------------------------------------
package decision_pkg;

    localparam int NUM_CLASSES = 5;
    localparam int ANSWER_W    = 3;
    localparam int VOTE_W      = 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DECIDE  = 2'd2
    } vote_state_t;

    // True when a sample code names one of the real classes (0..4).
    function automatic logic class_code_ok(input logic [ANSWER_W-1:0] code);
        return (code < ANSWER_W'(NUM_CLASSES));
    endfunction

endpackage

// File: rtl/answer_voter_if.sv
// -----------------------------------------------------------------------------
// answer_voter_if
// Sample stream in, decision pulses out.
//   sampleAnswer / sampleValid : per-sample class code and qualifier
//   finalAnswer                : winning class, held until the next decision
//   finalDone                  : one-cycle pulse, finalAnswer valid
//   noDecision                 : one-cycle pulse, window closed below threshold
//   busy                       : voter is scanning/deciding, samples dropped
// master = sample producer, slave = voter.
// -----------------------------------------------------------------------------
interface answer_voter_if;
    import decision_pkg::*;

    logic [ANSWER_W-1:0] sampleAnswer;
    logic                sampleValid;
    logic [ANSWER_W-1:0] finalAnswer;
    logic                finalDone;
    logic                noDecision;
    logic                busy;

    modport master (
        output sampleAnswer, sampleValid,
        input  finalAnswer, finalDone, noDecision, busy
    );

    modport slave (
        input  sampleAnswer, sampleValid,
        output finalAnswer, finalDone, noDecision, busy
    );

endinterface

// File: rtl/vote_bank.sv
// -----------------------------------------------------------------------------
// vote_bank
// One 8-bit vote counter per class. A counter is incremented by naming its
// class code; all counters clear together; one counter is read by index.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every counter (wins over inc_en)
//   inc_en     : increment the counter selected by inc_code
//   inc_code   : class code to increment (codes >= NUM_CLASSES hit nothing)
//   rd_idx     : class index to read
//   rd_data    : vote count of class rd_idx (0 for out-of-range index)
// -----------------------------------------------------------------------------
module vote_bank
    import decision_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc_en,
    input  logic [ANSWER_W-1:0] inc_code,
    input  logic [ANSWER_W-1:0] rd_idx,
    output logic [VOTE_W-1:0]   rd_data
);

    logic [VOTE_W-1:0] votes_r [NUM_CLASSES];

    // Vote counters: clear, or bump the counter whose class matches inc_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                votes_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                votes_r[i] <= '0;
            end
        end else if (inc_en) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (inc_code == ANSWER_W'(i)) begin
                    votes_r[i] <= votes_r[i] + VOTE_W'(1);
                end else begin
                    votes_r[i] <= votes_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                votes_r[i] <= votes_r[i];
            end
        end
    end

    // Indexed read port; an index past the last class reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rd_idx == ANSWER_W'(i)) begin
                rd_data = votes_r[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/answer_voter.sv
// -----------------------------------------------------------------------------
// answer_voter
// Majority vote over a window of WINDOW valid samples. When the window fills,
// five SCAN cycles pick the class with the most votes (ties go to the lowest
// class), then DECIDE either registers finalAnswer and pulses finalDone, or
// pulses noDecision when the winner has fewer than MIN_VOTES votes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : answer_voter_if.slave (samples in, decision outputs out)
// Parameters:
//   WINDOW     : valid samples per decision (1..255)
//   MIN_VOTES  : minimum winning vote count (1..WINDOW)
//   TIMEOUT    : idle cycles before a partial window is scanned
// Build option:
//   VOTE_TIMEOUT_EN : when defined, a partially filled window that sees no
//                     accepted sample for TIMEOUT cycles is closed early.
// -----------------------------------------------------------------------------
module answer_voter
    import decision_pkg::*;
#(
    parameter int WINDOW    = 16,
    parameter int MIN_VOTES = 9,
    parameter int TIMEOUT   = 1000
)(
    input  logic           clk,
    input  logic           rst_n,
    answer_voter_if.slave  bus
);

    localparam logic [ANSWER_W-1:0] LAST_IDX = ANSWER_W'(NUM_CLASSES - 1);

    // Reject configurations the 8-bit counters and the threshold cannot honour.
    if (WINDOW < 1 || WINDOW > 255 || MIN_VOTES < 1 || MIN_VOTES > WINDOW ||
        TIMEOUT < 1) begin : g_cfg_err
        $error("answer_voter: illegal WINDOW/MIN_VOTES/TIMEOUT");
    end

    vote_state_t         state_r;
    logic [VOTE_W-1:0]   cnt_r;
    logic [ANSWER_W-1:0] scan_idx_r;
    logic [VOTE_W-1:0]   best_r;
    logic [ANSWER_W-1:0] best_idx_r;
    logic [ANSWER_W-1:0] answer_r;
    logic                done_r;
    logic                nodec_r;
    logic                busy_r;

    logic                accept_s;
    logic                timeout_s;
    logic                clr_s;
    logic [VOTE_W-1:0]   cnt_next_s;
    logic [VOTE_W-1:0]   rd_data_s;

    // Only real class codes seen while collecting count toward the window.
    assign accept_s   = (state_r == ST_COLLECT) && bus.sampleValid &&
                        class_code_ok(bus.sampleAnswer);
    assign cnt_next_s = cnt_r + VOTE_W'(1);
    assign clr_s      = (state_r == ST_DECIDE);

    vote_bank u_vote_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .inc_en   (accept_s),
        .inc_code (bus.sampleAnswer),
        .rd_idx   (scan_idx_r),
        .rd_data  (rd_data_s)
    );

`ifdef VOTE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_r;

    // Idle counter: counts quiet cycles of a partly filled window, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r <= '0;
        end else if ((state_r != ST_COLLECT) || accept_s || (cnt_r == '0)) begin
            idle_r <= '0;
        end else if (idle_r != IDLE_W'(TIMEOUT)) begin
            idle_r <= idle_r + IDLE_W'(1);
        end else begin
            idle_r <= idle_r;
        end
    end

    assign timeout_s = (state_r == ST_COLLECT) && (cnt_r != '0) &&
                       (idle_r == IDLE_W'(TIMEOUT));
`else
    assign timeout_s = 1'b0;
`endif

    // Voter FSM with sample count, scan/compare and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_COLLECT;
            cnt_r      <= '0;
            scan_idx_r <= '0;
            best_r     <= '0;
            best_idx_r <= '0;
            answer_r   <= '0;
            done_r     <= 1'b0;
            nodec_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            // Decision outputs are single-cycle pulses.
            done_r  <= 1'b0;
            nodec_r <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        cnt_r <= cnt_next_s;
                        if (cnt_next_s == VOTE_W'(WINDOW)) begin
                            state_r    <= ST_SCAN;
                            scan_idx_r <= '0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ST_SCAN;
                        scan_idx_r <= '0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_SCAN: begin
                    // best_r enters at zero, so class 0 is the starting
                    // candidate; strict '>' keeps the lowest index on ties.
                    if (rd_data_s > best_r) begin
                        best_r     <= rd_data_s;
                        best_idx_r <= scan_idx_r;
                    end else begin
                        best_r <= best_r;
                    end
                    if (scan_idx_r == LAST_IDX) begin
                        state_r <= ST_DECIDE;
                    end else begin
                        scan_idx_r <= scan_idx_r + ANSWER_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (best_r >= VOTE_W'(MIN_VOTES)) begin
                        answer_r <= best_idx_r;
                        done_r   <= 1'b1;
                    end else begin
                        nodec_r <= 1'b1;
                    end
                    // Votes clear through clr_s on this same edge.
                    cnt_r      <= '0;
                    best_r     <= '0;
                    best_idx_r <= '0;
                    scan_idx_r <= '0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_COLLECT;
                end
                default: begin
                    state_r    <= ST_COLLECT;
                    cnt_r      <= '0;
                    scan_idx_r <= '0;
                    best_r     <= '0;
                    best_idx_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.finalAnswer = answer_r;
    assign bus.finalDone   = done_r;
    assign bus.noDecision  = nodec_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_answer_voter.sv
// -----------------------------------------------------------------------------
// tb_answer_voter
// Directed bench for answer_voter (WINDOW=16, MIN_VOTES=8, TIMEOUT=20).
// Honours VOTE_TIMEOUT_EN for the idle-window scenario.
// -----------------------------------------------------------------------------
module tb_answer_voter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done_seen;
    int   nodec_seen;

    answer_voter_if bus ();

    answer_voter #(
        .WINDOW    (16),
        .MIN_VOTES (8),
        .TIMEOUT   (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled away from the rising edge.
    always @(negedge clk) begin
        if (bus.finalDone)  done_seen  = done_seen + 1;
        if (bus.noDecision) nodec_seen = nodec_seen + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One valid sample on the next rising edge.
    task automatic feed(input logic [2:0] code);
        bus.sampleAnswer = code;
        bus.sampleValid  = 1'b1;
        @(posedge clk); #1;
        bus.sampleValid  = 1'b0;
    endtask

    task automatic feed_n(input logic [2:0] code, input int n);
        for (int i = 0; i < n; i++) feed(code);
    endtask

    // Called just after E0; walks E1..E6, optionally driving junk samples.
    task automatic wait_decision(input string tag, input bit exp_done,
                                 input logic [2:0] exp_ans, input bit junk);
        check_val({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            if (junk) begin
                bus.sampleAnswer = 3'd0;
                bus.sampleValid  = 1'b1;
            end
            @(posedge clk); #1;
            bus.sampleValid = 1'b0;
            if (k < 6) begin
                check_val({tag, "_busy_mid"}, {31'd0, bus.busy}, 32'd1);
                check_val({tag, "_pulse_early"},
                          {30'd0, bus.finalDone, bus.noDecision}, 32'd0);
            end else begin
                check_val({tag, "_done"},  {31'd0, bus.finalDone},  {31'd0, exp_done});
                check_val({tag, "_nodec"}, {31'd0, bus.noDecision}, {31'd0, !exp_done});
                check_val({tag, "_answer"}, {29'd0, bus.finalAnswer}, {29'd0, exp_ans});
                check_val({tag, "_busy_e6"}, {31'd0, bus.busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int d0;
        int n0;
        total = 0;
        bad = 0;
        done_seen = 0;
        nodec_seen = 0;
        rst_n = 1'b0;
        bus.sampleAnswer = 3'd0;
        bus.sampleValid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_answer", {29'd0, bus.finalAnswer}, 32'd0);
        check_val("rst_done",   {31'd0, bus.finalDone},   32'd0);
        check_val("rst_nodec",  {31'd0, bus.noDecision},  32'd0);
        check_val("rst_busy",   {31'd0, bus.busy},        32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16 x code 2: decision 2 six clocks after the last sample.
        feed_n(3'd2, 16);
        wait_decision("all2", 1'b1, 3'd2, 1'b0);
        @(posedge clk); #1;
        check_val("all2_pulse_width", {31'd0, bus.finalDone}, 32'd0);

        // 8 x 3 then 8 x 1: tie at threshold goes to the lower class.
        feed_n(3'd3, 8);
        feed_n(3'd1, 8);
        wait_decision("tie", 1'b1, 3'd1, 1'b0);

        // 5/5/5/1 spread: below threshold, answer keeps 1.
        feed_n(3'd0, 5);
        feed_n(3'd1, 5);
        feed_n(3'd2, 5);
        feed(3'd4);
        wait_decision("spread", 1'b0, 3'd1, 1'b0);

        // 7/7/2: one vote short of threshold.
        feed_n(3'd0, 7);
        feed_n(3'd1, 7);
        feed_n(3'd2, 2);
        wait_decision("short", 1'b0, 3'd1, 1'b0);

        // Codes 5..7 interleaved with 16 x code 4; junk code 0 during busy.
        for (int i = 0; i < 15; i++) begin
            feed(3'd4);
            feed(3'(5 + (i % 3)));
        end
        feed(3'd4);
        wait_decision("invalid", 1'b1, 3'd4, 1'b1);

        // Next window starts at E7; the busy-time junk must not count.
        feed_n(3'd1, 15);
        d0 = done_seen;
        n0 = nodec_seen;
        repeat (8) @(posedge clk);
        #1;
        check_val("open15_busy", {31'd0, bus.busy}, 32'd0);
        check_val("open15_pulses", done_seen + nodec_seen, d0 + n0);
        feed(3'd1);
        wait_decision("after_drop", 1'b1, 3'd1, 1'b0);

        // Reset during SCAN: no pulse, outputs cleared, votes discarded.
        feed_n(3'd3, 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d0 = done_seen;
        n0 = nodec_seen;
        rst_n = 1'b0;
        #1;
        check_val("scanrst_answer", {29'd0, bus.finalAnswer}, 32'd0);
        check_val("scanrst_busy",   {31'd0, bus.busy},        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("scanrst_pulses", done_seen + nodec_seen, d0 + n0);
        feed_n(3'd4, 9);
        feed_n(3'd3, 7);
        wait_decision("post_rst", 1'b1, 3'd4, 1'b0);

        // 10 x code 0 then idle.
        feed_n(3'd0, 10);
        d0 = done_seen;
        n0 = nodec_seen;
        repeat (60) @(posedge clk);
        #1;
`ifdef VOTE_TIMEOUT_EN
        check_val("timeout_done_cnt", done_seen, d0 + 1);
        check_val("timeout_answer", {29'd0, bus.finalAnswer}, 32'd0);
`else
        check_val("no_timeout_done_cnt", done_seen, d0);
        check_val("no_timeout_answer", {29'd0, bus.finalAnswer}, 32'd4);
`endif
        check_val("idle_nodec_cnt", nodec_seen, n0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/answer_voter.md
# answer_voter

Majority-vote producer for the `finalAnswer`/`finalDone` interface consumed by the output decision logic. It accepts a stream of per-sample classifications and tallies votes for classes 0..4 over a fixed window. When the window closes, it selects the winning class and issues a one-cycle `finalDone` pulse with `finalAnswer` registered. If no class reaches the vote threshold, it pulses `noDecision` instead.

## Interface
Parameters:
- `WINDOW`, default 16: valid samples per decision; legal range 1..255.
- `MIN_VOTES`, default 9: minimum winner vote count for a decision; legal range 1..`WINDOW`.
- `TIMEOUT`, default 1000: idle-cycle limit; used only when `VOTE_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sampleAnswer`  in  3  per-sample class code; 0..4 valid.
- `sampleValid`  in  1  `sampleAnswer` qualifier, one sample per cycle.
- `finalAnswer`  out  3  winning class; holds until next decision.
- `finalDone`  out  1  one-cycle pulse; `finalAnswer` is valid while it is high.
- `noDecision`  out  1  one-cycle pulse; window closed below threshold.
- `busy`  out  1  high when state ≠ COLLECT; samples are dropped while high.

## Operation
- Reset: all outputs 0, all vote counters 0, sample count 0, state COLLECT.
- FSM states: COLLECT → SCAN → DECIDE → COLLECT.
- COLLECT:
  - On `sampleValid` with code ≤ 4: increment `votes[code]` and the sample count.
  - Codes 5..7 are ignored entirely: not counted, not windowed.
  - The sample that brings the count to `WINDOW` moves the state to SCAN.
- SCAN: 5 cycles, index 0..4, one class per cycle.
  - Replace best if `votes[idx]` > best, strictly greater, so ties resolve to the lowest index.
  - Best starts at votes[0] and index 0.
- DECIDE:
  - If best ≥ `MIN_VOTES`: register `finalAnswer` = best index and pulse `finalDone`.
  - Otherwise: pulse `noDecision`; `finalAnswer` is unchanged.
  - In both cases, clear all votes, the sample count and the best value, then return to COLLECT.
- Widths: vote counters and sample count are 8 bits. No overflow is possible within the legal parameter range.
- `sampleValid` with any code while `busy`: dropped, no effect.
- Reset mid-SCAN or mid-DECIDE: the window is abandoned, no pulse is issued, and all state is cleared.

## Timing
- Edge E0 captures the `WINDOW`-th sample. Edges E1..E5 perform SCAN. Edge E6 registers DECIDE results, and `finalDone`/`noDecision` are high from E6 to E7.
- Latency is 6 clocks from the final-sample edge to the pulse.
- `busy` is high after E0 through E6. Samples presented at E1..E6 are dropped; a sample at E7 is accepted.
- `finalDone` and `noDecision` are never high together and never high for more than one cycle.
- Minimum decision period is `WINDOW` + 6 cycles.

## Configuration
- `VOTE_TIMEOUT_EN` defined:
  - An idle counter runs in COLLECT while the sample count is > 0 and no accepted sample arrives. It clears on every accepted sample.
  - When it reaches `TIMEOUT`, the FSM enters SCAN with the partial window. The threshold still applies.
- `VOTE_TIMEOUT_EN` undefined:
  - No idle counter is built, and the `TIMEOUT` parameter is unused.
  - A window closes only on reaching `WINDOW` samples, so it may stay open indefinitely.

## Structure
- Shared package `decision_pkg` holds:
  - `NUM_CLASSES` = 5
  - `ANSWER_W` = 3
  - the FSM state enum
  - the class-code range check
- `decision_pkg` is shared with the output decision logic.
- One sub-module, `vote_bank`: 5 × 8-bit counters with increment-by-code, synchronous clear, and an indexed read port.
- `answer_voter` contains the FSM, sample count, scan/compare logic, output registers, and the optional timeout counter.

## Test plan
- Reset, then 16 samples of code 2 → at E6: `finalDone` pulse, `finalAnswer` = 2, `busy` high for E1..E6.
- Window of 8×code 3 and 8×code 1, `MIN_VOTES` = 8 → tie resolves to `finalAnswer` = 1.
- Window of 5 each of codes 0/1/2 plus 1×code 4 → `noDecision` pulse, no `finalDone`, `finalAnswer` keeps its prior value.
- Codes 5..7 interleaved with 16×code 4 → invalid codes are ignored and the decision is issued on the 16th code 4 (`finalAnswer` = 4). Samples driven during `busy` are dropped and are not counted in the next window.
- Assert `rst_n` low during SCAN → no pulse and outputs 0. A following clean window decides correctly.
- With `VOTE_TIMEOUT_EN` and `TIMEOUT` = 20: 10×code 0 then idle → SCAN starts when the idle count reaches 20, followed by a `finalDone` pulse with `finalAnswer` = 0. Without the macro, the same stimulus produces no pulse.
